hazard_ctrl_unit: RTL and testbench
===================================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter LOAD_STALL, default 1, range 1..3: bubble cycles inserted per load-use hazard.
REQ-002 SHALL have parameter FLUSH_SLOTS, default 1, range 1..2: consecutive IF/ID flush cycles per taken control transfer.
REQ-003 SHALL have parameter MD_LATENCY, default 4, range 1..15: cycles HI/LO stay busy after a multiply/divide leaves ID/EX.
REQ-004 SHALL have the following ports:
  clk  input  1  sole clock, rising edge
  rst_n  input  1  asynchronous, active-low reset
  id_ex_inst  input  32  instruction in ID/EX
  if_id_inst  input  32  instruction in IF/ID
  branch_taken  input  1  condition of the ID/EX conditional branch is true
  mem_stall  input  1  external memory wait; freezes the pipeline
  pc_write  output  1  PC update enable
  if_id_write  output  1  IF/ID update enable
  id_ex_clean  output  1  load a bubble into ID/EX
  if_id_flush  output  1  squash IF/ID contents
  hazard_stall  output  1  high whenever pc_write is 0

Function
REQ-005 SHALL detect a load (LW, LH, LHU, LB, LBU) in ID/EX: load-use when its rt is nonzero and equals IF/ID rs or rt.
REQ-006 SHALL detect a control transfer in ID/EX: BEQ, BNE, BGTZ, BGEZ, BLEZ, BLTZ with branch_taken=1; J; JAL; R-type JR or JALR.
REQ-007 SHALL detect a multiply/divide (R-type MULT, MULTU, DIV, DIVU) in ID/EX; on each such cycle md_cnt loads MD_LATENCY.
REQ-008 SHALL decrement md_cnt by 1 per unfrozen cycle while nonzero, saturating at 0; md_busy = (md_cnt != 0) or a multiply/divide is in ID/EX.
REQ-009 SHALL flag an md-hazard when md_busy and IF/ID holds MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV or DIVU.
REQ-010 SHALL implement FSM states IDLE, LSTALL, FLUSH2, with a 2-bit stall counter.
REQ-011 IDLE priority per cycle: load-use > md-hazard > control transfer > none.
REQ-012 Load-use in IDLE: pc_write=0, if_id_write=0, id_ex_clean=1, if_id_flush=0; if LOAD_STALL>1, go to LSTALL with counter=LOAD_STALL-1.
REQ-013 LSTALL: same outputs as REQ-012; decrement counter; return to IDLE after the cycle in which counter is 1.
REQ-014 md-hazard (IDLE, no load-use): outputs as REQ-012; state unchanged; repeats every cycle until md_busy clears.
REQ-015 Control transfer (IDLE, no higher-priority event): pc_write=1, if_id_write=1, id_ex_clean=0, if_id_flush=1; if FLUSH_SLOTS=2, go to FLUSH2.
REQ-016 FLUSH2: if_id_flush=1, other outputs as normal, return to IDLE; ID/EX content is ignored in this state.
REQ-017 No event: pc_write=1, if_id_write=1, id_ex_clean=0, if_id_flush=0.
REQ-018 mem_stall=1 overrides all: pc_write=0, if_id_write=0, id_ex_clean=0, if_id_flush=0; FSM, stall counter and md_cnt hold.
REQ-019 Outputs SHALL be combinational from state and inputs (zero-latency response); state updates on rising clk.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE, stall counter=0, md_cnt=0.
REQ-021 During and right after reset, with no hazard present, outputs SHALL be pc_write=1, if_id_write=1, id_ex_clean=0, if_id_flush=0, hazard_stall=0.
REQ-022 Reset asserted mid-LSTALL or mid-FLUSH2 SHALL abort the sequence; no residual stall or flush after release.

Structure
REQ-023 Opcode and funct constants SHALL come from the shared define header; FSM state encodings SHALL be added there.
REQ-024 md_cnt tracking SHALL be a sub-module md_busy_tracker (inputs clk, rst_n, start, freeze; output busy).

Verification
REQ-025 LOAD_STALL=2: id_ex=0x8E090000 (lw $9,0($16)), if_id=0x01295020 (add $10,$9,$9) -> pc_write=0, id_ex_clean=1 for exactly 2 cycles, then 1/0.
REQ-026 id_ex=0x8E000000 (lw $0), if_id=0x00005020 -> no stall; pc_write=1, id_ex_clean=0.
REQ-027 FLUSH_SLOTS=2: id_ex=0x08000000 (J) -> if_id_flush=1 for 2 consecutive cycles, pc_write=1 throughout.
REQ-028 MD_LATENCY=4: id_ex=0x012A0018 (mult $9,$10), next cycle if_id=0x00005812 (mflo $11) held -> stall until md_cnt reaches 0 (4 cycles after the mult leaves ID/EX), then pass.
REQ-029 mem_stall=1 for 3 cycles during LSTALL -> all four control outputs 0, counter frozen; after release the remaining stall cycle completes.
REQ-030 rst_n pulsed low mid-FLUSH2 -> if_id_flush=0 immediately, state IDLE on release.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared MIPS opcode/funct constants, FSM state encoding and decode helpers
// for the hazard control unit.
package hazard_ctrl_unit_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_JALR   = 6'h09;
    localparam logic [5:0] FN_MFHI   = 6'h10;
    localparam logic [5:0] FN_MTHI   = 6'h11;
    localparam logic [5:0] FN_MFLO   = 6'h12;
    localparam logic [5:0] FN_MTLO   = 6'h13;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_MULTU  = 6'h19;
    localparam logic [5:0] FN_DIV    = 6'h1A;
    localparam logic [5:0] FN_DIVU   = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LSTALL = 2'd1,
        ST_FLUSH2 = 2'd2
    } state_t;

    function automatic logic is_load(input logic [31:0] inst);
        return inst[31:26] inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

    function automatic logic is_md(input logic [31:0] inst);
        return (inst[31:26] == OP_RTYPE) &&
               (inst[5:0] inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    endfunction

    // Anything that reads or writes HI/LO must wait for the multiplier.
    function automatic logic is_md_user(input logic [31:0] inst);
        return (inst[31:26] == OP_RTYPE) &&
               (inst[5:0] inside {FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO,
                                  FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    endfunction

    function automatic logic is_ctrl(input logic [31:0] inst, input logic taken);
        logic w_br;
        w_br = (inst[31:26] inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ}) ||
               ((inst[31:26] == OP_REGIMM) && (inst[20:16] inside {RT_BLTZ, RT_BGEZ}));
        return (w_br && taken) ||
               (inst[31:26] inside {OP_J, OP_JAL}) ||
               ((inst[31:26] == OP_RTYPE) && (inst[5:0] inside {FN_JR, FN_JALR}));
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_md_busy_tracker.sv
// Tracks how long HI/LO stay busy after a multiply/divide leaves ID/EX.
module md_busy_tracker #(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic freeze,
    output logic busy
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!freeze) begin
            if (start)
                r_cnt <= 4'(MD_LATENCY);
            else if (r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    assign busy = (r_cnt != 4'd0) || start;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, HI/LO interlock and
// IF/ID flushing for taken control transfers, with memory-wait freeze.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int LOAD_STALL  = 1,
    parameter int FLUSH_SLOTS = 1,
    parameter int MD_LATENCY  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_ex_inst,
    input  logic [31:0] if_id_inst,
    input  logic        branch_taken,
    input  logic        mem_stall,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_clean,
    output logic        if_id_flush,
    output logic        hazard_stall
);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_scnt, w_scnt_nxt;
    logic       w_load_use, w_md_busy, w_md_hazard, w_ctrl;

    assign w_load_use = is_load(id_ex_inst) && (id_ex_inst[20:16] != 5'd0) &&
                        ((id_ex_inst[20:16] == if_id_inst[25:21]) ||
                         (id_ex_inst[20:16] == if_id_inst[20:16]));
    assign w_md_hazard = w_md_busy && is_md_user(if_id_inst);
    assign w_ctrl      = is_ctrl(id_ex_inst, branch_taken);

    md_busy_tracker #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_busy_tracker (
        .clk   (clk),
        .rst_n (rst_n),
        .start (is_md(id_ex_inst)),
        .freeze(mem_stall),
        .busy  (w_md_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_scnt  <= 2'd0;
        end else if (!mem_stall) begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        case (r_state)
            ST_IDLE: begin
                if (w_load_use) begin
                    if (LOAD_STALL > 1) begin
                        w_state_nxt = ST_LSTALL;
                        w_scnt_nxt  = 2'(LOAD_STALL - 1);
                    end
                end else if (!w_md_hazard && w_ctrl && (FLUSH_SLOTS == 2)) begin
                    w_state_nxt = ST_FLUSH2;
                end
            end
            ST_LSTALL: begin
                w_scnt_nxt = r_scnt - 2'd1;
                if (r_scnt <= 2'd1)
                    w_state_nxt = ST_IDLE;
            end
            ST_FLUSH2: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are combinational so a hazard is answered in the same cycle.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        id_ex_clean = 1'b0;
        if_id_flush = 1'b0;
        if (mem_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load_use || w_md_hazard) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_clean = 1'b1;
                    end else if (w_ctrl) begin
                        if_id_flush = 1'b1;
                    end
                end
                ST_LSTALL: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_clean = 1'b1;
                end
                ST_FLUSH2: if_id_flush = 1'b1;
                default: ;
            endcase
        end
    end

    assign hazard_stall = !pc_write;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed scoreboard bench for hazard_ctrl_unit with LOAD_STALL=2,
// FLUSH_SLOTS=2, MD_LATENCY=4.
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_ex_inst, if_id_inst;
    logic        branch_taken, mem_stall;
    logic        pc_write, if_id_write, id_ex_clean, if_id_flush, hazard_stall;

    int n_vec = 0;
    int n_err = 0;
    logic [4:0] sb_q[$];

    // {pc_write, if_id_write, id_ex_clean, if_id_flush, hazard_stall}
    localparam logic [4:0] PASS   = 5'b11000;
    localparam logic [4:0] STALL  = 5'b00101;
    localparam logic [4:0] FLUSH  = 5'b11010;
    localparam logic [4:0] FREEZE = 5'b00001;

    localparam logic [31:0] LW9     = 32'h8E090000;
    localparam logic [31:0] ADD99   = 32'h01295020;
    localparam logic [31:0] ADD90   = 32'h01205020;
    localparam logic [31:0] ADD09   = 32'h00095020;
    localparam logic [31:0] ADDX    = 32'h014B6020;
    localparam logic [31:0] BEQ     = 32'h10000000;
    localparam logic [31:0] JR      = 32'h03E00008;
    localparam logic [31:0] BLTZ    = 32'h04000000;
    localparam logic [31:0] J       = 32'h08000000;
    localparam logic [31:0] JAL     = 32'h0C000000;
    localparam logic [31:0] MULT    = 32'h012A0018;
    localparam logic [31:0] MULTU   = 32'h014B0019;
    localparam logic [31:0] MFLO    = 32'h00005812;
    localparam logic [31:0] MFHI    = 32'h00005810;

    hazard_ctrl_unit #(
        .LOAD_STALL (2),
        .FLUSH_SLOTS(2),
        .MD_LATENCY (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_ex_inst  (id_ex_inst),
        .if_id_inst  (if_id_inst),
        .branch_taken(branch_taken),
        .mem_stall   (mem_stall),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .id_ex_clean (id_ex_clean),
        .if_id_flush (if_id_flush),
        .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        logic [4:0] obs, expv;
        obs  = {pc_write, if_id_write, id_ex_clean, if_id_flush, hazard_stall};
        expv = sb_q.pop_front();
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] ie, input logic [31:0] fi,
                        input logic br, input logic ms, input logic [4:0] e);
        @(negedge clk);
        id_ex_inst   = ie;
        if_id_inst   = fi;
        branch_taken = br;
        mem_stall    = ms;
        sb_q.push_back(e);
        #2;
        check(tag);
    endtask

    initial begin
        rst_n = 1'b0; id_ex_inst = '0; if_id_inst = '0;
        branch_taken = 1'b0; mem_stall = 1'b0;
        #2;
        sb_q.push_back(PASS);
        check("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", '0, '0, 0, 0, PASS);

        step("lu_both_0", LW9, ADD99, 0, 0, STALL);
        step("lu_both_1", '0,  ADD99, 0, 0, STALL);
        step("lu_both_go", '0, ADD99, 0, 0, PASS);
        step("lu_rs_0", LW9, ADD90, 0, 0, STALL);
        step("lu_rs_1", '0,  ADD90, 0, 0, STALL);
        step("lu_rs_go", '0, ADD90, 0, 0, PASS);
        step("lu_rt_0", LW9, ADD09, 0, 0, STALL);
        step("lu_rt_1", '0,  ADD09, 0, 0, STALL);
        step("lu_rt_go", '0, ADD09, 0, 0, PASS);
        step("lu_nomatch", LW9, ADDX, 0, 0, PASS);
        step("lw_r0", 32'h8E000000, 32'h00005020, 0, 0, PASS);

        step("ms_lu_0", LW9, ADD99, 0, 0, STALL);
        for (int i = 0; i < 3; i++) step("ms_freeze", '0, ADD99, 0, 1, FREEZE);
        step("ms_lu_rem", '0, ADD99, 0, 0, STALL);
        step("ms_lu_go",  '0, ADD99, 0, 0, PASS);

        step("beq_nt",   BEQ, '0, 0, 0, PASS);
        step("beq_t",    BEQ, '0, 1, 0, FLUSH);
        step("beq_fl2",  LW9, ADD99, 0, 0, FLUSH);
        step("beq_done", '0, '0, 0, 0, PASS);
        step("jr",       JR, '0, 0, 0, FLUSH);
        step("jr_fl2",   '0, '0, 0, 0, FLUSH);
        step("bltz_t",   BLTZ, '0, 1, 0, FLUSH);
        step("bltz_fl2", '0, '0, 0, 0, FLUSH);
        step("j",        J, '0, 0, 0, FLUSH);
        step("j_fl2",    '0, '0, 0, 0, FLUSH);
        step("j_done",   '0, '0, 0, 0, PASS);

        step("jal",      JAL, '0, 0, 0, FLUSH);
        step("jal_fl2",  '0, '0, 0, 0, FLUSH);
        rst_n = 1'b0;
        #1;
        sb_q.push_back(PASS);
        check("rst_mid_fl2");
        @(negedge clk);
        rst_n = 1'b1;
        step("fl2_after_rst", '0, '0, 0, 0, PASS);

        step("lu_rst_0", LW9, ADD99, 0, 0, STALL);
        step("lu_rst_1", '0,  ADD99, 0, 0, STALL);
        rst_n = 1'b0;
        #1;
        sb_q.push_back(PASS);
        check("rst_mid_lstall");
        @(negedge clk);
        rst_n = 1'b1;
        step("ls_after_rst", '0, '0, 0, 0, PASS);

        step("md_mult", MULT, '0, 0, 0, PASS);
        step("md_w1", '0,  MFLO, 0, 0, STALL);
        step("md_w2_beq", BEQ, MFLO, 1, 0, STALL);
        step("md_w3", '0,  MFLO, 0, 0, STALL);
        step("md_w4", '0,  MFLO, 0, 0, STALL);
        step("md_go", '0,  MFLO, 0, 0, PASS);

        step("md_same", MULT, MULTU, 0, 0, STALL);
        for (int i = 0; i < 4; i++) step("md_drain", '0, '0, 0, 0, PASS);
        step("md_mfhi_free", '0, MFHI, 0, 0, PASS);

        step("md_mult2", MULT, '0, 0, 0, PASS);
        for (int i = 0; i < 3; i++) step("md_freeze", '0, MFLO, 0, 1, FREEZE);
        for (int i = 0; i < 4; i++) step("md_frz_wait", '0, MFLO, 0, 0, STALL);
        step("md_frz_go", '0, MFLO, 0, 0, PASS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
